// File: rtl/batalha_pkg.sv
// Shared definitions for the key matrix scanner and the column-multiplexed displayer.
package batalha_pkg;

  localparam int NUM_COLS_DEF = 5;
  localparam int NUM_ROWS_DEF = 7;
  localparam int COORD_W      = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    NEXT   = 2'd3
  } scan_state_t;

  // Bit position of key (c,r) in the 35-bit image, same layout as the displayer.
  function automatic int img_idx(input int c, input int r, input int rows = NUM_ROWS_DEF);
    return c * rows + r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One-key debouncer: the stable state flips after DEBOUNCE_SCANS consecutive disagreeing samples.
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample,
  input  logic sample_en,
  output logic stable,
  output logic press
);

  logic [2:0] cnt;
  logic       flip;

  assign flip  = sample_en && (sample != stable) && (cnt == 3'(DEBOUNCE_SCANS - 1));
  // Combinational so the top can latch the event on the same edge the stable bit flips.
  assign press = flip && !stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sample_en) begin
      if (sample == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/matriz_key_scanner.sv
// Column-strobed key matrix scanner with per-key debounce and a press-event handshake.
// Optional build macro GHOST_REJECT_EN discards column samples with more than one row active.
module matriz_key_scanner
  import batalha_pkg::*;
#(
  parameter int NUM_COLS       = NUM_COLS_DEF,
  parameter int NUM_ROWS       = NUM_ROWS_DEF,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUM_ROWS-1:0]          row_in,
  output logic [NUM_COLS-1:0]          colune_activator,
  output logic [NUM_COLS*NUM_ROWS-1:0] key_image,
  output logic                         key_valid,
  output logic [COORD_W-1:0]           key_x,
  output logic [COORD_W-1:0]           key_y,
  input  logic                         key_ack,
  output logic                         key_overrun,
  output logic                         frame_done
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  scan_state_t                  state;
  logic [COORD_W-1:0]           col;
  logic [SETTLE_W-1:0]          settle_cnt;
  logic [NUM_ROWS-1:0]          row_meta;
  logic [NUM_ROWS-1:0]          row_sync;
  logic                         sample_go;
  logic [NUM_COLS*NUM_ROWS-1:0] press_all;
  logic [NUM_ROWS-1:0]          press_row;
  logic [COORD_W-1:0]           press_y;
  logic                         press_any;
  logic                         press_multi;

  function automatic logic [NUM_COLS-1:0] col_strobe(input logic [COORD_W-1:0] c);
    return NUM_COLS'(1) << c;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

`ifdef GHOST_REJECT_EN
  assign sample_go = enable && (state == SAMPLE) && ((row_sync & (row_sync - NUM_ROWS'(1))) == '0);
`else
  assign sample_go = enable && (state == SAMPLE);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      col              <= '0;
      settle_cnt       <= '0;
      colune_activator <= '0;
      frame_done       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!enable) begin
        state            <= IDLE;
        col              <= '0;
        settle_cnt       <= '0;
        colune_activator <= '0;
      end else begin
        case (state)
          IDLE: begin
            state            <= DRIVE;
            settle_cnt       <= '0;
            colune_activator <= col_strobe(col);
          end
          DRIVE: begin
            if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) state <= SAMPLE;
            else settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
          SAMPLE: state <= NEXT;
          NEXT: begin
            state      <= DRIVE;
            settle_cnt <= '0;
            if (col == COORD_W'(NUM_COLS - 1)) begin
              col              <= '0;
              frame_done       <= 1'b1;
              colune_activator <= col_strobe('0);
            end else begin
              col              <= col + COORD_W'(1);
              colune_activator <= col_strobe(col + COORD_W'(1));
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      localparam int IDX = img_idx(c, r, NUM_ROWS);
      key_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_key (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample    (row_sync[r]),
        .sample_en (sample_go && (col == COORD_W'(c))),
        .stable    (key_image[IDX]),
        .press     (press_all[IDX])
      );
    end
  end

  // Only the sampled column can raise presses, so folding columns per row is lossless.
  always_comb begin
    press_row = '0;
    for (int c = 0; c < NUM_COLS; c++)
      for (int r = 0; r < NUM_ROWS; r++)
        press_row[r] = press_row[r] | press_all[img_idx(c, r, NUM_ROWS)];
  end

  always_comb begin
    press_y = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--)
      if (press_row[r]) press_y = COORD_W'(r);
  end

  assign press_any   = |press_row;
  assign press_multi = (press_row & (press_row - NUM_ROWS'(1))) != '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_valid   <= 1'b0;
      key_x       <= '0;
      key_y       <= '0;
      key_overrun <= 1'b0;
    end else begin
      if (key_valid && key_ack) key_valid <= 1'b0;
      if (press_any) begin
        if (key_valid) begin
          key_overrun <= 1'b1;
        end else begin
          key_valid <= 1'b1;
          key_x     <= col;
          key_y     <= press_y;
          if (press_multi) key_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matriz_key_scanner.sv
// Directed bench for matriz_key_scanner: a behavioural key matrix drives row_in from the strobe.
module tb_matriz_key_scanner;

  localparam int NC  = 5;
  localparam int NR  = 7;
  localparam int DEB = 3;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [NR-1:0] row_in;
  logic [NC-1:0] colune_activator;
  logic [NC*NR-1:0] key_image;
  logic          key_valid;
  logic [2:0]    key_x;
  logic [2:0]    key_y;
  logic          key_ack;
  logic          key_overrun;
  logic          frame_done;

  logic [NC*NR-1:0] pressed;
  int n_checks;
  int n_pass;
  int fd_seen;
  logic valid_seen;

  matriz_key_scanner dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .row_in           (row_in),
    .colune_activator (colune_activator),
    .key_image        (key_image),
    .key_valid        (key_valid),
    .key_x            (key_x),
    .key_y            (key_y),
    .key_ack          (key_ack),
    .key_overrun      (key_overrun),
    .frame_done       (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row_in = '0;
    for (int c = 0; c < NC; c++)
      if (colune_activator[c]) row_in = row_in | pressed[c*NR +: NR];
  end

  always @(negedge clk) begin
    if (frame_done) fd_seen++;
    if (key_valid) valid_seen = 1'b1;
  end

  typedef struct {
    int   c;
    int   r;
    int   frames;
    logic exp_bit;
    logic exp_valid;
  } press_vec_t;

  press_vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    key_ack = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int start;
    int cyc;
    start = fd_seen;
    cyc   = 0;
    while ((fd_seen - start) < n && cyc < n * 40 + 10) begin
      @(negedge clk);
      cyc++;
    end
    check("frame_count", 64'(fd_seen - start), 64'(n));
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
  endtask

  initial begin
    logic [NC-1:0] exp_act;
    int idx;
    n_checks = 0;
    n_pass   = 0;
    fd_seen  = 0;
    valid_seen = 1'b0;
    reset_n  = 1'b0;
    enable   = 1'b0;
    key_ack  = 1'b0;
    pressed  = '0;

    vecs[0] = '{c: 2, r: 4, frames: 3, exp_bit: 1'b1, exp_valid: 1'b1};
    vecs[1] = '{c: 0, r: 0, frames: 3, exp_bit: 1'b1, exp_valid: 1'b1};
    vecs[2] = '{c: 4, r: 6, frames: 3, exp_bit: 1'b1, exp_valid: 1'b1};
    vecs[3] = '{c: 3, r: 2, frames: 2, exp_bit: 1'b0, exp_valid: 1'b0};
    vecs[4] = '{c: 1, r: 5, frames: 1, exp_bit: 1'b0, exp_valid: 1'b0};

    // Reset and idle
    do_reset();
    check("rst_activator", 64'(colune_activator), 64'(0));
    check("rst_image", 64'(key_image), 64'(0));
    check("rst_valid", 64'(key_valid), 64'(0));
    check("rst_xy", 64'({key_x, key_y}), 64'(0));
    check("rst_overrun", 64'(key_overrun), 64'(0));
    fd_seen = 0;
    repeat (100) @(negedge clk);
    check("idle_frame_done", 64'(fd_seen), 64'(0));
    check("idle_activator", 64'(colune_activator), 64'(0));

    // Strobe order and frame period
    enable = 1'b1;
    for (int i = 0; i < 62; i++) begin
      @(negedge clk);
      exp_act = NC'(1) << ((i % 30) / 6);
      check($sformatf("strobe_%0d", i), 64'(colune_activator), 64'(exp_act));
      check($sformatf("frame_done_%0d", i), 64'(frame_done), 64'((i == 30) || (i == 60)));
    end

    // Single-key press table
    foreach (vecs[k]) begin
      do_reset();
      idx = vecs[k].c * NR + vecs[k].r;
      pressed[idx] = 1'b1;
      enable = 1'b1;
      wait_frames(vecs[k].frames);
      check($sformatf("v%0d_bit", k), 64'(key_image[idx]), 64'(vecs[k].exp_bit));
      check($sformatf("v%0d_valid", k), 64'(key_valid), 64'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) begin
        check($sformatf("v%0d_xy", k), 64'({key_x, key_y}), 64'({3'(vecs[k].c), 3'(vecs[k].r)}));
        repeat (10) @(negedge clk);
        check($sformatf("v%0d_hold", k), 64'({key_valid, key_x, key_y}),
              64'({1'b1, 3'(vecs[k].c), 3'(vecs[k].r)}));
        ack_pulse();
        check($sformatf("v%0d_ack", k), 64'(key_valid), 64'(0));
      end else begin
        ack_pulse();
        wait_frames(DEB - vecs[k].frames);
        check($sformatf("v%0d_late_valid", k), 64'({key_valid, key_x, key_y}),
              64'({1'b1, 3'(vecs[k].c), 3'(vecs[k].r)}));
        check($sformatf("v%0d_late_bit", k), 64'(key_image[idx]), 64'(1));
      end
      check($sformatf("v%0d_overrun", k), 64'(key_overrun), 64'(0));
    end

    // Bounce: key (0,0) toggles every frame
    do_reset();
    valid_seen = 1'b0;
    enable = 1'b1;
    for (int f = 0; f < 10; f++) begin
      pressed[0] = ~f[0];
      wait_frames(1);
    end
    check("bounce_bit", 64'(key_image[0]), 64'(0));
    check("bounce_valid_seen", 64'(valid_seen), 64'(0));

    // Overrun: second press while first event is pending
    do_reset();
    pressed[1*NR+1] = 1'b1;
    enable = 1'b1;
    wait_frames(3);
    check("ovr_first", 64'({key_valid, key_x, key_y}), 64'({1'b1, 3'd1, 3'd1}));
    pressed = '0;
    pressed[3*NR+5] = 1'b1;
    wait_frames(3);
    check("ovr_bit26", 64'(key_image[26]), 64'(1));
    check("ovr_xy", 64'({key_valid, key_x, key_y}), 64'({1'b1, 3'd1, 3'd1}));
    check("ovr_flag", 64'(key_overrun), 64'(1));
    ack_pulse();
    repeat (5) @(negedge clk);
    check("ovr_sticky", 64'(key_overrun), 64'(1));

    // Two rows on one column
    do_reset();
    pressed[28] = 1'b1;
    pressed[31] = 1'b1;
    enable = 1'b1;
    wait_frames(3);
`ifdef GHOST_REJECT_EN
    check("ghost_image", 64'(key_image), 64'(0));
    check("ghost_valid", 64'(key_valid), 64'(0));
    check("ghost_overrun", 64'(key_overrun), 64'(0));
`else
    check("ghost_image", 64'(key_image), 64'((64'(1) << 28) | (64'(1) << 31)));
    check("ghost_event", 64'({key_valid, key_x, key_y}), 64'({1'b1, 3'd4, 3'd0}));
    check("ghost_overrun", 64'(key_overrun), 64'(1));
`endif

    // Asynchronous reset mid-frame, leaving the image populated beforehand
    do_reset();
    pressed[18] = 1'b1;
    enable = 1'b1;
    wait_frames(3);
    repeat (8) @(negedge clk);
    check("pre_areset_bit", 64'(key_image[18]), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("areset_activator", 64'(colune_activator), 64'(0));
    check("areset_image", 64'(key_image), 64'(0));
    check("areset_valid", 64'(key_valid), 64'(0));
    check("areset_frame_done", 64'(frame_done), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
